// File: rtl/sram_cfg_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : sram_cfg_loader                                                |
// | Brief   : Framed serial config loader with parity/range check and commit |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sram_cfg_loader #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 15,
  parameter int MODE_W   = 2,
  parameter int MAX_ADDR = 32767,
  parameter int TIMEOUT  = 1024
) (
  input  logic              data_clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              data_valid,
  input  logic              data,
  output logic [DATA_W-1:0] SRAM_DATA_IN,
  output logic [ADDR_W-1:0] SRAM_ADDRESS_START,
  output logic [ADDR_W-1:0] SRAM_ADDRESS_END,
  output logic [MODE_W-1:0] SRAM_MODE,
  output logic              cfg_valid,
  output logic              cfg_update,
  output logic              busy,
  output logic              err_parity,
  output logic              err_range,
  output logic              err_timeout,
  output logic [15:0]       frame_count
);

  localparam int FRAME_BITS = DATA_W + 2*ADDR_W + MODE_W + 1;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);
  localparam int TMO_W      = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0]  c_last_bit  = CNT_W'(FRAME_BITS - 1);
  localparam logic [TMO_W-1:0]  c_tmo_last  = TMO_W'(TIMEOUT - 1);
  localparam logic [ADDR_W:0]   c_max_addr  = (ADDR_W+1)'(MAX_ADDR);
  localparam int                c_mode_lsb  = 1;
  localparam int                c_end_lsb   = MODE_W + 1;
  localparam int                c_start_lsb = ADDR_W + MODE_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [FRAME_BITS-1:0]   r_sr;
  logic [CNT_W-1:0]        r_bit_cnt;
  logic [TMO_W-1:0]        r_tmo_cnt;

  logic                    w_restart;
  logic                    w_shift;
  logic                    w_timeout;
  logic                    w_check;
  logic                    w_parity_ok;
  logic                    w_range_ok;
  logic                    w_commit;
  logic [DATA_W-1:0]       w_data;
  logic [ADDR_W-1:0]       w_start;
  logic [ADDR_W-1:0]       w_end;
  logic [MODE_W-1:0]       w_mode;

  assign w_data  = r_sr[FRAME_BITS-1 -: DATA_W];
  assign w_start = r_sr[c_start_lsb +: ADDR_W];
  assign w_end   = r_sr[c_end_lsb +: ADDR_W];
  assign w_mode  = r_sr[c_mode_lsb +: MODE_W];

  // Even parity: the whole frame, parity bit included, must XOR to zero.
  assign w_parity_ok = ~(^r_sr);
  assign w_range_ok  = (w_start <= w_end) && ({1'b0, w_end} <= c_max_addr);
  assign w_commit    = w_check && w_parity_ok && w_range_ok;

  assign busy = (r_state == S_SHIFT) || (r_state == S_CHECK);

  always_ff @(posedge data_clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_restart   = 1'b0;
    w_shift     = 1'b0;
    w_timeout   = 1'b0;
    w_check     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (frame_start) begin
          w_restart   = 1'b1;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // A restart wins over a coincident data bit, which is dropped.
        if (frame_start) begin
          w_restart = 1'b1;
        end else if (data_valid) begin
          w_shift = 1'b1;
          if (r_bit_cnt == c_last_bit) begin
            w_state_nxt = S_CHECK;
          end
        end else if (r_tmo_cnt == c_tmo_last) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_CHECK: begin
        w_check     = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge data_clk or posedge reset) begin
    if (reset) begin
      r_sr               <= '0;
      r_bit_cnt          <= '0;
      r_tmo_cnt          <= '0;
      SRAM_DATA_IN       <= '0;
      SRAM_ADDRESS_START <= '0;
      SRAM_ADDRESS_END   <= '0;
      SRAM_MODE          <= '0;
      cfg_valid          <= 1'b0;
      cfg_update         <= 1'b0;
      err_parity         <= 1'b0;
      err_range          <= 1'b0;
      err_timeout        <= 1'b0;
      frame_count        <= '0;
    end else begin
      cfg_update <= 1'b0;

      if (w_restart) begin
        r_sr        <= '0;
        r_bit_cnt   <= '0;
        r_tmo_cnt   <= '0;
        err_parity  <= 1'b0;
        err_range   <= 1'b0;
        err_timeout <= 1'b0;
      end else if (w_shift) begin
        r_sr      <= {r_sr[FRAME_BITS-2:0], data};
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        r_tmo_cnt <= '0;
      end else if (w_timeout) begin
        r_tmo_cnt   <= '0;
        err_timeout <= 1'b1;
      end else if (r_state == S_SHIFT) begin
        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
      end

      if (w_check) begin
        if (!w_parity_ok) begin
          err_parity <= 1'b1;
        end
        if (!w_range_ok) begin
          err_range <= 1'b1;
        end
      end

      // All four fields move together so consumers never see a mixed config.
      if (w_commit) begin
        SRAM_DATA_IN       <= w_data;
        SRAM_ADDRESS_START <= w_start;
        SRAM_ADDRESS_END   <= w_end;
        SRAM_MODE          <= w_mode;
        cfg_valid          <= 1'b1;
        cfg_update         <= 1'b1;
        frame_count        <= frame_count + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_cfg_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_sram_cfg_loader                                             |
// | Brief   : Randomized frame-level checks of sram_cfg_loader               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_sram_cfg_loader;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 15;
  localparam int MODE_W   = 2;
  localparam int MAX_ADDR = 32767;
  localparam int FB       = DATA_W + 2*ADDR_W + MODE_W + 1;

  logic data_clk = 1'b0;
  logic reset = 1'b1;
  logic frame_start = 1'b0;
  logic data_valid = 1'b0;
  logic data = 1'b0;

  logic [DATA_W-1:0] sram_data, sram_data_t;
  logic [ADDR_W-1:0] sram_start, sram_start_t, sram_end, sram_end_t;
  logic [MODE_W-1:0] sram_mode, sram_mode_t;
  logic cfg_valid, cfg_valid_t, cfg_update, cfg_update_t, busy, busy_t;
  logic err_parity, err_parity_t, err_range, err_range_t, err_timeout, err_timeout_t;
  logic [15:0] frame_count, frame_count_t;

  sram_cfg_loader dut (
    .data_clk(data_clk), .reset(reset), .frame_start(frame_start),
    .data_valid(data_valid), .data(data),
    .SRAM_DATA_IN(sram_data), .SRAM_ADDRESS_START(sram_start),
    .SRAM_ADDRESS_END(sram_end), .SRAM_MODE(sram_mode),
    .cfg_valid(cfg_valid), .cfg_update(cfg_update), .busy(busy),
    .err_parity(err_parity), .err_range(err_range), .err_timeout(err_timeout),
    .frame_count(frame_count)
  );

  sram_cfg_loader #(.TIMEOUT(16)) dut_t (
    .data_clk(data_clk), .reset(reset), .frame_start(frame_start),
    .data_valid(data_valid), .data(data),
    .SRAM_DATA_IN(sram_data_t), .SRAM_ADDRESS_START(sram_start_t),
    .SRAM_ADDRESS_END(sram_end_t), .SRAM_MODE(sram_mode_t),
    .cfg_valid(cfg_valid_t), .cfg_update(cfg_update_t), .busy(busy_t),
    .err_parity(err_parity_t), .err_range(err_range_t), .err_timeout(err_timeout_t),
    .frame_count(frame_count_t)
  );

  always #5 data_clk = ~data_clk;

  int checks = 0;
  int failures = 0;
  int upd_n = 0;
  int upd_n_t = 0;

  // Reference model of the committed configuration.
  logic [DATA_W-1:0] exp_data;
  logic [ADDR_W-1:0] exp_start, exp_end;
  logic [MODE_W-1:0] exp_mode;
  logic              exp_valid, exp_ep, exp_er, exp_et, exp_et_t;
  logic [15:0]       exp_count;

  always @(negedge data_clk) begin
    if (cfg_update)   upd_n++;
    if (cfg_update_t) upd_n_t++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge data_clk);
    #1;
  endtask

  task automatic model_reset();
    exp_data = '0; exp_start = '0; exp_end = '0; exp_mode = '0;
    exp_valid = 1'b0; exp_ep = 1'b0; exp_er = 1'b0; exp_et = 1'b0; exp_et_t = 1'b0;
    exp_count = '0;
  endtask

  task automatic model_frame_start();
    exp_ep = 1'b0; exp_er = 1'b0; exp_et = 1'b0; exp_et_t = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic eb, input logic ebt);
    check({tag, "_data"},   32'(sram_data),     32'(exp_data));
    check({tag, "_start"},  32'(sram_start),    32'(exp_start));
    check({tag, "_end"},    32'(sram_end),      32'(exp_end));
    check({tag, "_mode"},   32'(sram_mode),     32'(exp_mode));
    check({tag, "_valid"},  32'(cfg_valid),     32'(exp_valid));
    check({tag, "_update"}, 32'(cfg_update),    32'(0));
    check({tag, "_count"},  32'(frame_count),   32'(exp_count));
    check({tag, "_eparity"},32'(err_parity),    32'(exp_ep));
    check({tag, "_erange"}, 32'(err_range),     32'(exp_er));
    check({tag, "_etmo"},   32'(err_timeout),   32'(exp_et));
    check({tag, "_busy"},   32'(busy),          32'(eb));
    check({tag, "_t_data"}, 32'(sram_data_t),   32'(exp_data));
    check({tag, "_t_start"},32'(sram_start_t),  32'(exp_start));
    check({tag, "_t_end"},  32'(sram_end_t),    32'(exp_end));
    check({tag, "_t_count"},32'(frame_count_t), 32'(exp_count));
    check({tag, "_t_etmo"}, 32'(err_timeout_t), 32'(exp_et_t));
    check({tag, "_t_busy"}, 32'(busy_t),        32'(ebt));
  endtask

  // Frame start may coincide with a data_valid bit that must be discarded.
  task automatic send_frame(input logic [FB-1:0] f, input int maxgap);
    frame_start = 1'b1;
    data_valid  = 1'($urandom_range(0, 1));
    data        = 1'($urandom_range(0, 1));
    model_frame_start();
    tick();
    frame_start = 1'b0;
    data_valid  = 1'b0;
    for (int i = FB-1; i >= 0; i--) begin
      repeat ($urandom_range(0, maxgap)) tick();
      data_valid = 1'b1;
      data       = f[i];
      tick();
      data_valid = 1'b0;
    end
  endtask

  task automatic send_partial(input int n);
    frame_start = 1'b1;
    model_frame_start();
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      data_valid = 1'b1;
      data       = 1'($urandom_range(0, 1));
      tick();
    end
    data_valid = 1'b0;
  endtask

  function automatic logic [FB-1:0] build(input logic [7:0] d, input logic [14:0] s,
                                          input logic [14:0] e, input logic [1:0] m,
                                          input bit flip);
    logic [FB-1:0] f;
    f    = {d, s, e, m, 1'b0};
    f[0] = (^f) ^ flip;
    return f;
  endfunction

  task automatic run_frame(input string tag, input logic [7:0] d, input logic [14:0] s,
                           input logic [14:0] e, input logic [1:0] m, input bit flip,
                           input int maxgap);
    logic [FB-1:0] f;
    bit pok, rok, ok;
    int u0, u0t;
    f   = build(d, s, e, m, flip);
    pok = ((^f) == 1'b0);
    rok = (s <= e) && (int'(e) <= MAX_ADDR);
    ok  = pok && rok;
    u0  = upd_n;
    u0t = upd_n_t;
    send_frame(f, maxgap);
    check({tag, "_busy_chk"}, 32'(busy), 32'(1));
    tick();
    check({tag, "_pulse"}, 32'(cfg_update), 32'(ok));
    if (!pok) exp_ep = 1'b1;
    if (!rok) exp_er = 1'b1;
    if (ok) begin
      exp_data  = d;
      exp_start = s;
      exp_end   = e;
      exp_mode  = m;
      exp_valid = 1'b1;
      exp_count = exp_count + 16'd1;
    end
    tick();
    check({tag, "_npulse"},   32'(upd_n - u0),    32'(ok));
    check({tag, "_npulse_t"}, 32'(upd_n_t - u0t), 32'(ok));
    check_all(tag, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0]  d;
    logic [14:0] s, e;
    logic [1:0]  m;
    int          sel;

    model_reset();
    repeat (2) tick();
    check_all("reset", 1'b0, 1'b0);
    reset = 1'b0;
    tick();

    run_frame("t1", 8'hA5, 15'h0010, 15'h7FFF, 2'd2, 1'b0, 0);
    run_frame("t2", 8'hA5, 15'h0010, 15'h7FFF, 2'd2, 1'b1, 0);
    run_frame("t3a", 8'h3C, 15'h0100, 15'h00FF, 2'd1, 1'b0, 2);
    run_frame("t3b", 8'h5A, 15'h0100, 15'h0100, 2'd3, 1'b0, 2);

    send_partial(20);
    check_all("t4p", 1'b1, 1'b1);
    run_frame("t4", 8'hC3, 15'h1234, 15'h4321, 2'd1, 1'b0, 5);

    for (int k = 0; k < 30; k++) begin
      d   = 8'($urandom);
      s   = 15'($urandom);
      m   = 2'($urandom);
      sel = $urandom_range(0, 3);
      case (sel)
        0:       e = s;
        1:       e = 15'($urandom);
        2:       e = s - 15'd1;
        default: e = s + 15'($urandom_range(0, 32767 - int'(s)));
      endcase
      if ($urandom_range(0, 4) == 0) send_partial($urandom_range(1, FB - 1));
      run_frame("rnd", d, s, e, m, ($urandom_range(0, 3) == 0), 5);
    end

    // Idle timeout on the short-timeout instance only.
    send_partial(10);
    repeat (15) tick();
    check("t5_pre_busy_t", 32'(busy_t), 32'(1));
    check("t5_pre_etmo_t", 32'(err_timeout_t), 32'(0));
    tick();
    exp_et_t = 1'b1;
    check_all("t5", 1'b1, 1'b0);
    run_frame("t5b", 8'h77, 15'h0001, 15'h0002, 2'd0, 1'b0, 3);

    // Reset while in CHECK: outputs clear without any clock edge.
    send_frame(build(8'h11, 15'h0003, 15'h0004, 2'd1, 1'b0), 0);
    reset = 1'b1;
    #1;
    model_reset();
    check_all("t6_chk", 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    check_all("t6_chk_post", 1'b0, 1'b0);

    run_frame("t6a", 8'h99, 15'h0020, 15'h0030, 2'd2, 1'b0, 1);
    send_partial(20);
    reset = 1'b1;
    #1;
    model_reset();
    check_all("t6_shift", 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    tick();

    run_frame("t6b", 8'h42, 15'h0000, 15'h7FFF, 2'd3, 1'b0, 1);
    force dut.frame_count = 16'hFFFF;
    force dut_t.frame_count = 16'hFFFF;
    #1;
    release dut.frame_count;
    release dut_t.frame_count;
    exp_count = 16'hFFFF;
    run_frame("t6_wrap", 8'h24, 15'h0005, 15'h0006, 2'd0, 1'b0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
